// File: rtl/tis_port_reader_if.sv
// Bundle of node-side and neighbour-side signals for the TIS-100 port reader.
// The master side is the node plus its four neighbours; the slave side is the reader.
interface tis_port_reader_if #(
  parameter int unsigned WORD_SIZE = 11
);

  // Node request side
  logic                   req;
  logic [2:0]             src;
  logic [WORD_SIZE-1:0]   rdata;
  logic                   rvalid;
  logic                   busy;
  logic [2:0]             last_dir;

  // Neighbour side; bit/slice index 0=LEFT 1=RIGHT 2=UP 3=DOWN
  logic [3:0]             nbr_valid;
  logic [4*WORD_SIZE-1:0] nbr_data;
  logic [3:0]             nbr_ack;

  modport master (
    output req, src, nbr_valid, nbr_data,
    input  nbr_ack, rdata, rvalid, busy, last_dir
  );

  modport slave (
    input  req, src, nbr_valid, nbr_data,
    output nbr_ack, rdata, rvalid, busy, last_dir
  );

endinterface

// File: rtl/tis_port_reader.sv
// TIS-100 blocking port reader: stalls the node until the selected neighbour
// offers a word, acks it, returns it registered, and tracks the LAST direction.
module tis_port_reader #(
  parameter int unsigned WORD_SIZE = 11
) (
  input  logic              CLK,
  input  logic              nRST,
  tis_port_reader_if.slave  bus
);

  typedef enum logic [2:0] {
    SRC_NIL   = 3'b000,
    SRC_ACC   = 3'b001,
    SRC_LEFT  = 3'b010,
    SRC_RIGHT = 3'b011,
    SRC_UP    = 3'b100,
    SRC_DOWN  = 3'b101,
    SRC_ANY   = 3'b110,
    SRC_LAST  = 3'b111
  } src_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t               r_state,    w_state_nxt;
  src_t                 r_sel,      w_sel_nxt;
  src_t                 r_last_dir, w_last_nxt;
  logic [WORD_SIZE-1:0] r_rdata,    w_rdata_nxt;
  logic                 r_rvalid,   w_rvalid_nxt;

  src_t                 w_src_in;
  logic [WORD_SIZE-1:0] w_words [4];
  logic [1:0]           w_idx;
  logic                 w_match;
  logic                 w_take;
  logic [3:0]           w_ack;

  // Map a bus bit index back to its src_t direction code.
  function automatic src_t idx_to_src(input logic [1:0] idx);
    case (idx)
      2'd0:    return SRC_LEFT;
      2'd1:    return SRC_RIGHT;
      2'd2:    return SRC_UP;
      default: return SRC_DOWN;
    endcase
  endfunction

  // Map a fixed direction code to its bus bit index.
  function automatic logic [1:0] src_to_idx(input src_t s);
    case (s)
      SRC_LEFT:  return 2'd0;
      SRC_RIGHT: return 2'd1;
      SRC_UP:    return 2'd2;
      SRC_DOWN:  return 2'd3;
      default:   return 2'd0;
    endcase
  endfunction

  assign w_src_in = src_t'(bus.src);

  // Split the packed neighbour data bus into per-direction words.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      w_words[i] = bus.nbr_data[i*WORD_SIZE +: WORD_SIZE];
    end
  end

  // Resolve which neighbour is being served this cycle; ANY picks the
  // lowest-index offering neighbour so LEFT wins over RIGHT over UP over DOWN.
  always_comb begin
    w_idx   = '0;
    w_match = 1'b0;
    if (r_sel == SRC_ANY) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (!w_match && bus.nbr_valid[i]) begin
          w_idx   = i[1:0];
          w_match = 1'b1;
        end
      end
    end else begin
      w_idx   = src_to_idx(r_sel);
      w_match = bus.nbr_valid[w_idx];
    end
  end

  // A take only happens while waiting with a live match; reset suppresses it
  // so an aborted read never consumes a neighbour's word.
  assign w_take = (r_state == ST_WAIT) && w_match && nRST;
  assign w_ack  = w_take ? (4'b0001 << w_idx) : '0;

  // Next-state and register-update logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_last_nxt   = r_last_dir;
    w_rdata_nxt  = r_rdata;
    w_rvalid_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req) begin
          case (w_src_in)
            SRC_LEFT, SRC_RIGHT, SRC_UP, SRC_DOWN, SRC_ANY: begin
              w_sel_nxt   = w_src_in;
              w_state_nxt = ST_WAIT;
            end
            SRC_LAST: begin
              if (r_last_dir != SRC_NIL) begin
                w_sel_nxt   = r_last_dir;
                w_state_nxt = ST_WAIT;
              end else begin
                w_rdata_nxt  = '0;
                w_rvalid_nxt = 1'b1;
              end
            end
            default: begin
              // NIL and ACC both read as zero without waiting
              w_rdata_nxt  = '0;
              w_rvalid_nxt = 1'b1;
            end
          endcase
        end
      end
      ST_WAIT: begin
        if (w_take) begin
          w_rdata_nxt  = w_words[w_idx];
          w_rvalid_nxt = 1'b1;
          w_state_nxt  = ST_IDLE;
          if (r_sel == SRC_ANY) begin
            w_last_nxt = idx_to_src(w_idx);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state    <= ST_IDLE;
      r_sel      <= SRC_NIL;
      r_last_dir <= SRC_NIL;
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_last_dir <= w_last_nxt;
      r_rdata    <= w_rdata_nxt;
      r_rvalid   <= w_rvalid_nxt;
    end
  end

  assign bus.nbr_ack  = w_ack;
  assign bus.rdata    = r_rdata;
  assign bus.rvalid   = r_rvalid;
  assign bus.busy     = (r_state == ST_WAIT);
  assign bus.last_dir = r_last_dir;

  a_ack_onehot0 : assert property (@(posedge CLK) $onehot0(bus.nbr_ack));
  a_ack_valid   : assert property (@(posedge CLK) (bus.nbr_ack & ~bus.nbr_valid) == 4'b0000);

endmodule

// File: tb/tb_tis_port_reader.sv
// Bench for tis_port_reader: directed test-plan scenarios followed by random
// traffic, all checked against a transaction-level model of the read port.
module tb_tis_port_reader;

  localparam int unsigned W = 11;

  localparam logic [2:0] S_NIL   = 3'b000;
  localparam logic [2:0] S_ACC   = 3'b001;
  localparam logic [2:0] S_LEFT  = 3'b010;
  localparam logic [2:0] S_RIGHT = 3'b011;
  localparam logic [2:0] S_UP    = 3'b100;
  localparam logic [2:0] S_DOWN  = 3'b101;
  localparam logic [2:0] S_ANY   = 3'b110;
  localparam logic [2:0] S_LAST  = 3'b111;

  logic clk;
  logic nrst;

  tis_port_reader_if #(.WORD_SIZE(W)) bus ();

  tis_port_reader #(.WORD_SIZE(W)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Model: is a read outstanding, which direction (-1 = ANY), LAST memory
  // (-1 = NIL, else 0..3), and the registered outputs after the next edge.
  bit           m_pend;
  int           m_dir;
  int           m_last;
  logic [W-1:0] m_rdata;
  bit           m_rvalid;

  logic [2:0] dir_code [4] = '{S_LEFT, S_RIGHT, S_UP, S_DOWN};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [2:0] last_code(input int l);
    return (l < 0) ? S_NIL : dir_code[l];
  endfunction

  // One clock cycle: check registered outputs, apply inputs, check the
  // combinational outputs, then advance the model across the coming edge.
  task automatic step(input bit rq, input logic [2:0] s, input logic [3:0] v,
                      input logic [4*W-1:0] d, input bit rst);
    int         pick;
    logic [3:0] e_ack;
    @(negedge clk);
    check_eq("rvalid",   {31'b0, bus.rvalid}, {31'b0, m_rvalid});
    check_eq("rdata",    {21'b0, bus.rdata},  {21'b0, m_rdata});
    check_eq("last_dir", {29'b0, bus.last_dir}, {29'b0, last_code(m_last)});
    nrst          = rst;
    bus.req       = rq;
    bus.src       = s;
    bus.nbr_valid = v;
    bus.nbr_data  = d;
    #1;
    pick = -1;
    if (m_pend && rst) begin
      if (m_dir < 0) begin
        for (int i = 0; i < 4; i++) if (pick < 0 && v[i]) pick = i;
      end else if (v[m_dir]) begin
        pick = m_dir;
      end
    end
    e_ack = (pick >= 0) ? 4'(1 << pick) : 4'b0000;
    check_eq("nbr_ack", {28'b0, bus.nbr_ack}, {28'b0, e_ack});
    check_eq("busy",    {31'b0, bus.busy},    {31'b0, m_pend});

    m_rvalid = 1'b0;
    if (!rst) begin
      m_pend  = 1'b0;
      m_last  = -1;
      m_rdata = '0;
    end else if (m_pend) begin
      if (pick >= 0) begin
        m_rdata  = d[pick*W +: W];
        m_rvalid = 1'b1;
        if (m_dir < 0) m_last = pick;
        m_pend = 1'b0;
      end
    end else if (rq) begin
      case (s)
        S_LEFT:  begin m_pend = 1'b1; m_dir = 0;  end
        S_RIGHT: begin m_pend = 1'b1; m_dir = 1;  end
        S_UP:    begin m_pend = 1'b1; m_dir = 2;  end
        S_DOWN:  begin m_pend = 1'b1; m_dir = 3;  end
        S_ANY:   begin m_pend = 1'b1; m_dir = -1; end
        S_LAST: begin
          if (m_last >= 0) begin
            m_pend = 1'b1;
            m_dir  = m_last;
          end else begin
            m_rdata  = '0;
            m_rvalid = 1'b1;
          end
        end
        default: begin
          m_rdata  = '0;
          m_rvalid = 1'b1;
        end
      endcase
    end
  endtask

  logic [4*W-1:0] d0;
  logic [63:0]    r64;

  initial begin
    d0 = '0;
    nrst = 1'b0;
    bus.req = 1'b0;
    bus.src = S_NIL;
    bus.nbr_valid = 4'b0000;
    bus.nbr_data = '0;
    repeat (3) @(posedge clk);
    m_pend = 1'b0; m_dir = 0; m_last = -1; m_rdata = '0; m_rvalid = 1'b0;

    // NIL read from reset state returns zero one cycle later
    step(1'b1, S_NIL, 4'b0000, d0, 1'b1);
    step(1'b0, S_ACC, 4'b0000, d0, 1'b1);
    step(1'b1, S_ACC, 4'b0000, d0, 1'b1);
    step(1'b0, S_NIL, 4'b0000, d0, 1'b1);

    // UP with five idle cycles, then UP offers 0x5A3
    step(1'b1, S_UP, 4'b0000, d0, 1'b1);
    repeat (5) step(1'b1, S_UP, 4'b1011, {W'(11'h111), W'(0), W'(11'h222), W'(11'h333)}, 1'b1);
    step(1'b1, S_UP, 4'b0100, {W'(0), W'(11'h5A3), W'(0), W'(0)}, 1'b1);
    step(1'b0, S_NIL, 4'b0000, d0, 1'b1);
    check_eq("up_rdata", {21'b0, bus.rdata}, 32'h5A3);
    check_eq("up_last_nil", {29'b0, bus.last_dir}, {29'b0, S_NIL});

    // ANY with RIGHT and DOWN offering: RIGHT wins
    step(1'b1, S_ANY, 4'b0000, d0, 1'b1);
    step(1'b1, S_ANY, 4'b1010, {W'(11'h7FF), W'(0), W'(11'h001), W'(0)}, 1'b1);
    step(1'b0, S_NIL, 4'b0000, d0, 1'b1);
    check_eq("any_rdata", {21'b0, bus.rdata}, 32'h001);
    check_eq("any_last_dir", {29'b0, bus.last_dir}, {29'b0, S_RIGHT});

    // LAST now means RIGHT; LEFT and DOWN offers must be ignored
    step(1'b1, S_LAST, 4'b1001, {W'(11'h444), W'(0), W'(0), W'(11'h555)}, 1'b1);
    repeat (3) step(1'b1, S_LAST, 4'b1001, {W'(11'h444), W'(0), W'(0), W'(11'h555)}, 1'b1);
    step(1'b1, S_LAST, 4'b0010, {W'(0), W'(0), W'(11'h2C6), W'(0)}, 1'b1);
    step(1'b0, S_NIL, 4'b0000, d0, 1'b1);
    check_eq("last_rdata", {21'b0, bus.rdata}, 32'h2C6);

    // Reset, unset LAST returns zero, LEFT accepted back-to-back
    step(1'b0, S_NIL, 4'b0000, d0, 1'b0);
    step(1'b1, S_LAST, 4'b0000, d0, 1'b1);
    step(1'b1, S_LEFT, 4'b0001, {W'(0), W'(0), W'(0), W'(11'h0AB)}, 1'b1);
    step(1'b1, S_LEFT, 4'b0001, {W'(0), W'(0), W'(0), W'(11'h0AB)}, 1'b1);
    step(1'b0, S_NIL, 4'b0000, d0, 1'b1);

    // DOWN aborted by reset in WAIT cycle 2 as DOWN becomes valid
    step(1'b1, S_DOWN, 4'b0000, d0, 1'b1);
    step(1'b1, S_DOWN, 4'b0000, d0, 1'b1);
    step(1'b1, S_DOWN, 4'b1000, {W'(11'h6E1), W'(0), W'(0), W'(0)}, 1'b0);
    step(1'b0, S_NIL, 4'b1000, {W'(11'h6E1), W'(0), W'(0), W'(0)}, 1'b1);
    check_eq("abort_busy", {31'b0, bus.busy}, 32'h0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] v;
      for (int b = 0; b < 4; b++) v[b] = ($urandom_range(0, 9) < 3);
      r64 = {$urandom(), $urandom()};
      step($urandom_range(0, 9) < 6, 3'($urandom_range(0, 7)), v, r64[4*W-1:0],
           $urandom_range(0, 99) != 0);
    end
    step(1'b0, S_NIL, 4'b0000, d0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
